// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode through the IF/ID register.
// Ports: clk, rst (sync, active-high); stall, redirect_valid/redirect_addr in;
//   imem_addr out / imem_data in (combinational instruction memory read);
//   if_valid/if_instr/if_pc (IF/ID register), halted, fetch_count out.
module fetch_unit #(
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [5:0]  HALT_OP  = 6'h3F,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_data,
    output logic              if_valid,
    output logic [WORD_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                valid_q, valid_d;
    logic [WORD_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]   ifpc_q, ifpc_d;
    logic                halted_q, halted_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                is_halt;
    logic [CNT_W-1:0]    cnt_inc;

    assign is_halt = (imem_data[WORD_W-1 -: 6] == HALT_OP);
    // Counter sticks at all-ones instead of wrapping.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            ifpc_q   <= '0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            ifpc_q   <= ifpc_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        ifpc_d   = ifpc_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (redirect_valid) begin
                    pc_d    = redirect_addr;
                    valid_d = 1'b0;
                    instr_d = '0;
                end else if (!stall) begin
                    instr_d = imem_data;
                    ifpc_d  = pc_q;
                    valid_d = 1'b1;
                    cnt_d   = cnt_inc;
                    // Halt word is still delivered; pc parks on it.
                    if (is_halt) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
            end
            S_HALT: begin
                if (redirect_valid) begin
                    pc_d     = redirect_addr;
                    halted_d = 1'b0;
                    valid_d  = 1'b0;
                    instr_d  = '0;
                    state_d  = S_RUN;
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        imem_addr   = pc_q;
        if_valid    = valid_q;
        if_instr    = instr_q;
        if_pc       = ifpc_q;
        halted      = halted_q;
        fetch_count = cnt_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit.
// A second instance with a 4-bit counter shares stimulus to check saturation.
module tb_fetch_unit;

    localparam int WW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          stall;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;
    logic [AW-1:0] imem_addr;
    logic [WW-1:0] imem_data;
    logic          if_valid;
    logic [WW-1:0] if_instr;
    logic [AW-1:0] if_pc;
    logic          halted;
    logic [15:0]   fetch_count;

    logic [AW-1:0] s_imem_addr;
    logic [WW-1:0] s_imem_data;
    logic          s_if_valid;
    logic [WW-1:0] s_if_instr;
    logic [AW-1:0] s_if_pc;
    logic          s_halted;
    logic [3:0]    s_fetch_count;

    logic [WW-1:0] mem [32];

    int checks;
    int failures;

    typedef struct {
        logic          v;
        logic [AW-1:0] pc;
        logic [WW-1:0] instr;
        logic          ci;
        int            cnt;
        logic          h;
        logic [AW-1:0] a;
    } exp_t;

    exp_t sb [$];

    localparam logic [WW-1:0] HALT_W = 32'hFC00_0000;

    assign imem_data   = mem[imem_addr];
    assign s_imem_data = mem[s_imem_addr];

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .halted(halted),
        .fetch_count(fetch_count)
    );

    fetch_unit #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr),
        .imem_addr(s_imem_addr), .imem_data(s_imem_data),
        .if_valid(s_if_valid), .if_instr(s_if_instr),
        .if_pc(s_if_pc), .halted(s_halted),
        .fetch_count(s_fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic rv,
                        input logic [AW-1:0] ra, input logic ev,
                        input logic [AW-1:0] epc, input logic [WW-1:0] ei,
                        input logic ci, input int ecnt, input logic eh,
                        input logic [AW-1:0] ea);
        exp_t e;
        rst            = r;
        stall          = s;
        redirect_valid = rv;
        redirect_addr  = ra;
        e.v = ev; e.pc = epc; e.instr = ei; e.ci = ci;
        e.cnt = ecnt; e.h = eh; e.a = ea;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("if_valid", 32'(if_valid), 32'(e.v));
        if (e.v) chk("if_pc", 32'(if_pc), 32'(e.pc));
        if (e.ci) chk("if_instr", if_instr, e.instr);
        chk("fetch_count", 32'(fetch_count), 32'(e.cnt));
        chk("halted", 32'(halted), 32'(e.h));
        chk("imem_addr", 32'(imem_addr), 32'(e.a));
        chk("sat_count", 32'(s_fetch_count),
            32'((e.cnt > 15) ? 15 : e.cnt));
    endtask

    task automatic fetch(input int k, input int cnt);
        logic [AW-1:0] p;
        logic [AW-1:0] n;
        p = AW'(k);
        n = AW'(k + 1);
        step(0, 0, 0, '0, 1, p, 32'h100 + 32'(k), 1, cnt, 0, n);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h100 + 32'(i);

        // Reset, IDLE bubble, sequential fetch
        step(1, 0, 0, '0, 0, '0, '0, 1, 0, 0, 5'd0);
        step(1, 0, 0, '0, 0, '0, '0, 1, 0, 0, 5'd0);
        step(0, 1, 1, 5'd9, 0, '0, '0, 1, 0, 0, 5'd0);
        for (int k = 0; k <= 4; k++) fetch(k, k + 1);

        // Stall holds everything
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, '0, 1, 5'd4, 32'h104, 1, 5, 0, 5'd5);
        fetch(5, 6);

        // Redirect beats stall, one bubble
        step(0, 1, 1, 5'd20, 0, '0, '0, 1, 6, 0, 5'd20);
        fetch(20, 7);
        fetch(21, 8);

        // Wrap from 31 to 0
        step(0, 0, 1, 5'd30, 0, '0, '0, 1, 8, 0, 5'd30);
        fetch(30, 9);
        fetch(31, 10);
        fetch(0, 11);
        fetch(1, 12);

        // Halt opcode at 6
        mem[6] = HALT_W;
        for (int k = 2; k <= 5; k++) fetch(k, k + 11);
        step(0, 0, 0, '0, 1, 5'd6, HALT_W, 1, 17, 1, 5'd6);
        step(0, 1, 0, '0, 1, 5'd6, HALT_W, 1, 17, 1, 5'd6);
        step(0, 0, 0, '0, 0, '0, HALT_W, 1, 17, 1, 5'd6);
        step(0, 0, 0, '0, 0, '0, HALT_W, 1, 17, 1, 5'd6);
        mem[6] = 32'h106;
        step(0, 1, 1, 5'd0, 0, '0, '0, 0, 17, 0, 5'd0);
        for (int k = 0; k <= 11; k++) fetch(k, k + 18);

        // Reset mid-run overrides stall and redirect
        step(1, 1, 1, 5'd25, 0, '0, '0, 1, 0, 0, 5'd0);
        step(0, 0, 0, '0, 0, '0, '0, 1, 0, 0, 5'd0);
        for (int k = 0; k < 20; k++) fetch(k, k + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
